// File: rtl/hs_pkg.sv
// rtl/hs_pkg.sv - shared state encoding and default geometry for the hiscore RAM bridge
package hs_pkg;

    localparam int HS_AW = 11;
    localparam int HS_DW = 8;

    typedef enum logic [1:0] {
        ST_CPU     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_HS      = 2'd2,
        ST_RELEASE = 2'd3
    } hs_state_e;

endpackage

// File: rtl/spram_sync.sv
// rtl/spram_sync.sv - inferred single-port RAM, synchronous write, one-clock registered read
module spram_sync #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rdata_d;
    logic [DW-1:0] rdata_q;

    // Read-before-write: a write cycle returns the old contents of that address.
    always_comb begin
        rdata_d = mem[addr];
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        rdata_q <= rdata_d;
    end

    assign dout = rdata_q;

endmodule

// File: rtl/hs_ram_bridge.sv
// rtl/hs_ram_bridge.sv - arbitrates one work RAM between the CPU and the hiscore engine
module hs_ram_bridge
    import hs_pkg::*;
#(
    parameter int AW = HS_AW,
    parameter int DW = HS_DW
) (
    input  logic          clock_12,
    input  logic          reset,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    input  logic          cpu_cs,
    input  logic          cpu_we,
    input  logic          cpu_ce,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_hold,
    input  logic          hs_access,
    input  logic [AW-1:0] hs_address,
    input  logic [DW-1:0] hs_data_in,
    input  logic          hs_write,
    output logic [DW-1:0] hs_data_out,
    output logic          hs_grant
);

    hs_state_e     state_q, state_d;
    logic          cpu_src_q, cpu_src_d;
    logic          hs_src_q, hs_src_d;
    logic [DW-1:0] cpu_dout_q, cpu_dout_d;
    logic [DW-1:0] hs_dout_q, hs_dout_d;

    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we_raw;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;
    logic          cpu_wr;

    assign cpu_wr = cpu_cs & cpu_we & cpu_ce;

    always_comb begin
        state_d    = state_q;
        ram_addr   = cpu_addr;
        ram_din    = cpu_din;
        ram_we_raw = 1'b0;
        cpu_hold   = 1'b1;
        hs_grant   = 1'b0;
        unique case (state_q)
            ST_CPU: begin
                cpu_hold   = 1'b0;
                ram_we_raw = cpu_wr;
                if (hs_access) begin
                    state_d = ST_DRAIN;
                end
            end
            // The CPU finishes its in-flight bus cycle before the RAM changes hands.
            ST_DRAIN: begin
                ram_we_raw = cpu_wr;
                if (!hs_access) begin
                    state_d = ST_CPU;
                end else if (cpu_ce) begin
                    state_d = ST_HS;
                end
            end
            ST_HS: begin
                hs_grant   = 1'b1;
                ram_addr   = hs_address;
                ram_din    = hs_data_in;
                ram_we_raw = hs_write;
                if (!hs_access) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_CPU;
            end
            default: begin
                state_d = ST_CPU;
            end
        endcase
    end

    assign ram_we = ram_we_raw & ~reset;

    // The RAM read port is shared, so remember whose address produced the current rdata.
    always_comb begin
        cpu_src_d  = (state_q != ST_HS);
        hs_src_d   = (state_q == ST_HS);
        cpu_dout_d = cpu_dout;
        hs_dout_d  = hs_data_out;
    end

    assign cpu_dout    = cpu_src_q ? ram_rdata : cpu_dout_q;
    assign hs_data_out = hs_src_q ? ram_rdata : hs_dout_q;

    always_ff @(posedge clock_12) begin
        if (reset) begin
            state_q    <= ST_CPU;
            cpu_src_q  <= 1'b0;
            hs_src_q   <= 1'b0;
            cpu_dout_q <= '0;
            hs_dout_q  <= '0;
        end else begin
            state_q    <= state_d;
            cpu_src_q  <= cpu_src_d;
            hs_src_q   <= hs_src_d;
            cpu_dout_q <= cpu_dout_d;
            hs_dout_q  <= hs_dout_d;
        end
    end

    spram_sync #(
        .AW(AW),
        .DW(DW)
    ) u_ram (
        .clk (clock_12),
        .we  (ram_we),
        .addr(ram_addr),
        .din (ram_din),
        .dout(ram_rdata)
    );

endmodule
